// File: rtl/dc_mmu_pkg.sv
// Shared definitions for the data-cache miss responder.
//   LINE_W_DEF : default cache line width in bits
//   CNT_W_DEF  : default performance counter width
//   state_t    : responder FSM state encoding
package dc_mmu_pkg;

    localparam int LINE_W_DEF = 128;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EVICT   = 3'd1,
        FILL    = 3'd2,
        MACK    = 3'd3,
        IO      = 3'd4,
        IOACK   = 3'd5,
        RECOVER = 3'd6
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for performance statistics.
//   clk : clock (rising edge)
//   rst : asynchronous active-high reset, clears the count
//   inc : increment request for this cycle
//   cnt : current count; holds at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/dc_miss_responder.sv
// Services data-cache line fills (with optional dirty-victim writeback)
// against a line-wide memory port, and uncached word accesses against
// an IO bus. One transaction at a time; a one-cycle RECOVER state after
// every ack keeps a still-held request from being serviced twice.
//   clk, rst                      : clock, asynchronous active-high reset
//   dc_miss/_addr, dc_evict/_addr/_data : fill request and victim line
//   dc_data_fill, dc_miss_ack     : fill line and one-cycle fill-complete pulse
//   io_access, io_rw, io_addr, io_wr_data : uncached request (io_rw=1 write)
//   io_rd_data, io_ack            : IO read data and one-cycle complete pulse
//   mem_req/we/addr/wdata, mem_rdata, mem_ack : line memory port
//   iob_req/we/addr/wdata, iob_rdata, iob_ack : IO bus port
//   perf_miss_cnt, perf_evict_cnt : saturating fill / writeback counts
module dc_miss_responder
    import dc_mmu_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dc_miss,
    input  logic [31:0]       dc_miss_addr,
    input  logic              dc_evict,
    input  logic [31:0]       dc_evict_addr,
    input  logic [LINE_W-1:0] dc_evict_data,
    output logic [LINE_W-1:0] dc_data_fill,
    output logic              dc_miss_ack,
    input  logic              io_access,
    input  logic              io_rw,
    input  logic [31:0]       io_addr,
    input  logic [31:0]       io_wr_data,
    output logic [31:0]       io_rd_data,
    output logic              io_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              iob_req,
    output logic              iob_we,
    output logic [31:0]       iob_addr,
    output logic [31:0]       iob_wdata,
    input  logic [31:0]       iob_rdata,
    input  logic              iob_ack,
    output logic [CNT_W-1:0]  perf_miss_cnt,
    output logic [CNT_W-1:0]  perf_evict_cnt
);

    state_t state, state_n;

    logic [31:0]       miss_addr;
    logic [31:0]       evict_addr;
    logic [LINE_W-1:0] evict_data;
    logic [LINE_W-1:0] fill_line;
    logic [31:0]       io_addr_q;
    logic              io_rw_q;
    logic [31:0]       io_wdata_q;
    logic [31:0]       io_rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Request fields are captured only when leaving IDLE, so the bus
    // outputs stay stable for the whole transaction even if the
    // requester changes its inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_addr  <= '0;
            evict_addr <= '0;
            evict_data <= '0;
            fill_line  <= '0;
            io_addr_q  <= '0;
            io_rw_q    <= 1'b0;
            io_wdata_q <= '0;
            io_rdata_q <= '0;
        end else begin
            if (state == IDLE && dc_miss) begin
                miss_addr  <= dc_miss_addr;
                evict_addr <= dc_evict_addr;
                evict_data <= dc_evict_data;
            end else if (state == IDLE && io_access) begin
                io_addr_q  <= io_addr;
                io_rw_q    <= io_rw;
                io_wdata_q <= io_wr_data;
            end
            if (state == FILL && mem_ack) begin
                fill_line <= mem_rdata;
            end
            // Writes return no data; present zero on the ack cycle.
            if (state == IO && iob_ack) begin
                io_rdata_q <= io_rw_q ? 32'd0 : iob_rdata;
            end
        end
    end

    always_comb begin
        state_n      = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        iob_req      = 1'b0;
        iob_we       = 1'b0;
        iob_addr     = '0;
        iob_wdata    = '0;
        dc_miss_ack  = 1'b0;
        dc_data_fill = '0;
        io_ack       = 1'b0;
        io_rd_data   = '0;
        case (state)
            IDLE: begin
                // A pending fill takes priority over an IO access.
                if (dc_miss) begin
                    state_n = dc_evict ? EVICT : FILL;
                end else if (io_access) begin
                    state_n = IO;
                end
            end
            EVICT: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = evict_addr;
                mem_wdata = evict_data;
                if (mem_ack) state_n = FILL;
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = miss_addr;
                if (mem_ack) state_n = MACK;
            end
            MACK: begin
                dc_miss_ack  = 1'b1;
                dc_data_fill = fill_line;
                state_n      = RECOVER;
            end
            IO: begin
                iob_req   = 1'b1;
                iob_we    = io_rw_q;
                iob_addr  = io_addr_q;
                iob_wdata = io_wdata_q;
                if (iob_ack) state_n = IOACK;
            end
            IOACK: begin
                io_ack     = 1'b1;
                io_rd_data = io_rdata_q;
                state_n    = RECOVER;
            end
            RECOVER: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk (clk),
        .rst (rst),
        .inc (state == MACK),
        .cnt (perf_miss_cnt)
    );

    sat_counter #(.W(CNT_W)) u_evict_cnt (
        .clk (clk),
        .rst (rst),
        .inc ((state == EVICT) && mem_ack),
        .cnt (perf_evict_cnt)
    );

endmodule

// File: tb/tb_dc_miss_responder.sv
module tb_dc_miss_responder;

    localparam int LW = 128;
    localparam int CW = 16;

    logic          clk;
    logic          rst;
    logic          dc_miss;
    logic [31:0]   dc_miss_addr;
    logic          dc_evict;
    logic [31:0]   dc_evict_addr;
    logic [LW-1:0] dc_evict_data;
    logic [LW-1:0] dc_data_fill;
    logic          dc_miss_ack;
    logic          io_access;
    logic          io_rw;
    logic [31:0]   io_addr;
    logic [31:0]   io_wr_data;
    logic [31:0]   io_rd_data;
    logic          io_ack;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_ack;
    logic          iob_req;
    logic          iob_we;
    logic [31:0]   iob_addr;
    logic [31:0]   iob_wdata;
    logic [31:0]   iob_rdata;
    logic          iob_ack;
    logic [CW-1:0] perf_miss_cnt;
    logic [CW-1:0] perf_evict_cnt;

    dc_miss_responder #(.LINE_W(LW), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .dc_miss        (dc_miss),
        .dc_miss_addr   (dc_miss_addr),
        .dc_evict       (dc_evict),
        .dc_evict_addr  (dc_evict_addr),
        .dc_evict_data  (dc_evict_data),
        .dc_data_fill   (dc_data_fill),
        .dc_miss_ack    (dc_miss_ack),
        .io_access      (io_access),
        .io_rw          (io_rw),
        .io_addr        (io_addr),
        .io_wr_data     (io_wr_data),
        .io_rd_data     (io_rd_data),
        .io_ack         (io_ack),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .iob_req        (iob_req),
        .iob_we         (iob_we),
        .iob_addr       (iob_addr),
        .iob_wdata      (iob_wdata),
        .iob_rdata      (iob_rdata),
        .iob_ack        (iob_ack),
        .perf_miss_cnt  (perf_miss_cnt),
        .perf_evict_cnt (perf_evict_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          is_io;
        logic [127:0] data;
    } exp_t;

    exp_t        sb[$];
    int          vectors;
    int          miscompares;
    logic [15:0] exp_miss;
    logic [15:0] exp_evict;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {124'd0, mem_req, mem_we, iob_req, iob_we}, 128'd0);
        chk({tag, "_acks"}, {126'd0, dc_miss_ack, io_ack}, 128'd0);
        chk({tag, "_maddr"}, {96'd0, mem_addr}, 128'd0);
        chk({tag, "_mwdata"}, mem_wdata, 128'd0);
        chk({tag, "_fill"}, dc_data_fill, 128'd0);
        chk({tag, "_iobus"}, {32'd0, iob_addr, iob_wdata, io_rd_data}, 128'd0);
        chk({tag, "_cnts"}, {96'd0, perf_miss_cnt, perf_evict_cnt}, 128'd0);
    endtask

    task automatic sb_check(input string tag, input bit is_io, input logic [127:0] obs);
        exp_t e;
        chk({tag, "_sb_avail"}, {127'd0, sb.size() != 0}, 128'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_sb_kind"}, {127'd0, e.is_io}, {127'd0, is_io});
            chk({tag, "_sb_data"}, obs, e.data);
        end
    endtask

    task automatic sat_inc(inout logic [15:0] c);
        if (c != 16'hFFFF) c = c + 16'd1;
    endtask

    // Drives one fill (optionally with writeback); ws = wait cycles in FILL.
    task automatic miss_txn(input logic [31:0] a, input bit ev, input logic [31:0] va,
                            input logic [127:0] vd, input logic [127:0] rd, input int ws);
        dc_miss       = 1'b1;
        dc_miss_addr  = a;
        dc_evict      = ev;
        dc_evict_addr = va;
        dc_evict_data = vd;
        sb.push_back('{1'b0, rd});
        @(negedge clk);
        dc_miss_addr  = ~a;
        dc_evict_addr = ~va;
        dc_evict_data = ~vd;
        if (ev) begin
            chk("evict_ctl", {124'd0, mem_req, mem_we, iob_req, dc_miss_ack}, 128'b1100);
            chk("evict_addr", {96'd0, mem_addr}, {96'd0, va});
            chk("evict_data", mem_wdata, vd);
            mem_ack = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
            sat_inc(exp_evict);
            chk("evict_cnt", {112'd0, perf_evict_cnt}, {112'd0, exp_evict});
        end
        for (int i = 0; i < ws; i++) begin
            chk("fill_wait", {125'd0, mem_req, dc_miss_ack, iob_req}, 128'b100);
            iob_ack = 1'b1;
            @(negedge clk);
            iob_ack = 1'b0;
        end
        chk("fill_ctl", {124'd0, mem_req, mem_we, iob_req, dc_miss_ack}, 128'b1000);
        chk("fill_addr", {96'd0, mem_addr}, {96'd0, a});
        chk("fill_wdata", mem_wdata, 128'd0);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = ~rd;
        chk("mack_ctl", {125'd0, dc_miss_ack, mem_req, io_ack}, 128'b100);
        sb_check("mack", 1'b0, dc_data_fill);
        sat_inc(exp_miss);
        @(negedge clk);
        chk("recover_ctl", {124'd0, dc_miss_ack, mem_req, iob_req, io_ack}, 128'd0);
        chk("recover_fill", dc_data_fill, 128'd0);
        chk("miss_cnt", {112'd0, perf_miss_cnt}, {112'd0, exp_miss});
        chk("evict_cnt2", {112'd0, perf_evict_cnt}, {112'd0, exp_evict});
        dc_miss = 1'b0;
        @(negedge clk);
        chk("post_idle", {125'd0, mem_req, iob_req, dc_miss_ack}, 128'd0);
    endtask

    // Drives one IO access; ws = wait cycles in IO.
    task automatic io_txn(input bit rw, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int ws);
        io_access  = 1'b1;
        io_rw      = rw;
        io_addr    = a;
        io_wr_data = wd;
        sb.push_back('{1'b1, rw ? 128'd0 : {96'd0, rd}});
        @(negedge clk);
        io_addr    = ~a;
        io_wr_data = ~wd;
        io_rw      = ~rw;
        for (int i = 0; i < ws; i++) begin
            chk("io_wait", {125'd0, iob_req, io_ack, mem_req}, 128'b100);
            mem_ack = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
        end
        chk("io_ctl", {124'd0, iob_req, iob_we, mem_req, io_ack}, {124'd0, 1'b1, rw, 2'b00});
        chk("io_addr", {96'd0, iob_addr}, {96'd0, a});
        chk("io_wdata", {96'd0, iob_wdata}, {96'd0, wd});
        iob_ack   = 1'b1;
        iob_rdata = rd;
        @(negedge clk);
        iob_ack   = 1'b0;
        iob_rdata = ~rd;
        chk("ioack_ctl", {125'd0, io_ack, iob_req, dc_miss_ack}, 128'b100);
        sb_check("ioack", 1'b1, {96'd0, io_rd_data});
        @(negedge clk);
        chk("io_recover", {125'd0, io_ack, iob_req, mem_req}, 128'd0);
        chk("io_recover_data", {96'd0, io_rd_data}, 128'd0);
        io_access = 1'b0;
        io_rw     = 1'b0;
        @(negedge clk);
        chk("io_post_idle", {125'd0, io_ack, iob_req, mem_req}, 128'd0);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        exp_miss      = '0;
        exp_evict     = '0;
        rst           = 1'b1;
        dc_miss       = 1'b0;
        dc_miss_addr  = '0;
        dc_evict      = 1'b0;
        dc_evict_addr = '0;
        dc_evict_data = '0;
        io_access     = 1'b0;
        io_rw         = 1'b0;
        io_addr       = '0;
        io_wr_data    = '0;
        mem_rdata     = '0;
        mem_ack       = 1'b0;
        iob_rdata     = '0;
        iob_ack       = 1'b0;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("idle");

        // Plain fill, ack in cycle 3.
        miss_txn(32'h0000_1230, 1'b0, 32'h0, 128'h0, {16{8'hA5}}, 0);

        // Fill with writeback, ack in cycle 4 (plus one wait state).
        miss_txn(32'h0000_8880, 1'b1, 32'h0000_4560, {16{8'h11}}, {16{8'h5A}}, 1);

        // IO read and IO write.
        io_txn(1'b0, 32'h0000_F004, 32'h0, 32'hDEAD_BEEF, 0);
        io_txn(1'b1, 32'h0000_0100, 32'hCAFE_F00D, 32'h1234_5678, 2);

        // Simultaneous miss and IO: miss first, then IO.
        io_access  = 1'b1;
        io_rw      = 1'b0;
        io_addr    = 32'h0000_0200;
        io_wr_data = 32'h0;
        miss_txn(32'h0000_3340, 1'b0, 32'h0, 128'h0, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 0);
        io_txn(1'b0, 32'h0000_0200, 32'h0, 32'h0BAD_F00D, 0);

        // Reset during FILL aborts with no ack; held miss restarts.
        dc_miss      = 1'b1;
        dc_miss_addr = 32'h0000_2000;
        dc_evict     = 1'b0;
        @(negedge clk);
        chk("pre_abort_req", {127'd0, mem_req}, 128'd1);
        #2 rst = 1'b1;
        #1 chk_all_zero("abort");
        mem_ack = 1'b1;
        exp_miss  = '0;
        exp_evict = '0;
        @(negedge clk);
        chk("abort_noack", {126'd0, dc_miss_ack, mem_req}, 128'd0);
        mem_ack = 1'b0;
        rst     = 1'b0;
        miss_txn(32'h0000_2000, 1'b0, 32'h0, 128'h0, {4{32'h600D_CAFE}}, 0);

        // Saturation of the fill counter.
        force dut.u_miss_cnt.cnt = 16'hFFFF;
        @(negedge clk);
        release dut.u_miss_cnt.cnt;
        exp_miss = 16'hFFFF;
        chk("sat_forced", {112'd0, perf_miss_cnt}, {112'd0, exp_miss});
        miss_txn(32'h0000_7700, 1'b0, 32'h0, 128'h0, {16{8'h3C}}, 0);
        chk("sat_hold", {112'd0, perf_miss_cnt}, 128'hFFFF);

        chk("sb_drained", 128'(sb.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
